// File: rtl/sdram_read.sv
// Single-transaction SDRAM read engine: ACTIVE, READ with auto-precharge, CAS wait, burst capture.
// Define SDRAM_READ_REGIN_EN to register DRAM_DQ at the pins (adds one cycle of CAS wait).
//
//   state  | meaning
//   IDLE   | waiting for ireq with bus ownership
//   ACT    | BACT command on the bus, row/bank presented
//   NOP1   | tRCD spacing
//   RD     | READ with auto-precharge, column/bank presented
//   CASW   | waiting out CAS latency
//   CAPT   | one burst word captured per cycle
//   FIN    | ofin pulse, back to IDLE next cycle
module sdram_read #(
    parameter int CAS_LATENCY = 2,
    parameter int BURST_LEN   = 1
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        ireq,
    input  logic        ienb,
    output logic        ofin,
    input  logic [12:0] irow,
    input  logic [9:0]  icolumn,
    input  logic [1:0]  ibank,
    output logic [15:0] odata,
    output logic        ovalid,
    output logic        DRAM_CLK,
    output logic        DRAM_CKE,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic        DRAM_UDQM,
    output logic        DRAM_LDQM,
    input  logic [15:0] DRAM_DQ
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACT  = 3'd1;
    localparam logic [2:0] S_NOP1 = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_CASW = 3'd4;
    localparam logic [2:0] S_CAPT = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_BACT = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;

`ifdef SDRAM_READ_REGIN_EN
    localparam int CASW_CYCLES = CAS_LATENCY + 1;
`else
    localparam int CASW_CYCLES = CAS_LATENCY;
`endif
    localparam logic [3:0] CASW_LAST  = 4'(CASW_CYCLES - 1);
    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

    logic [2:0]  state_q, state_d;
    logic [12:0] row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic [1:0]  bank_q, bank_d;
    logic [3:0]  beat_q, beat_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [12:0] addr_q, addr_d;
    logic [1:0]  ba_q, ba_d;
    logic [1:0]  dqm_q, dqm_d;
    logic        ofin_q, ofin_d;
    logic        ovalid_q, ovalid_d;
    logic [15:0] odata_q, odata_d;
    logic [15:0] dq_sel;

`ifdef SDRAM_READ_REGIN_EN
    logic [15:0] dq_q;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            dq_q <= 16'h0000;
        end else begin
            dq_q <= DRAM_DQ;
        end
    end

    assign dq_sel = dq_q;
`else
    assign dq_sel = DRAM_DQ;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ireq && ienb) state_d = S_ACT;
            S_ACT:   state_d = S_NOP1;
            S_NOP1:  state_d = S_RD;
            S_RD:    state_d = S_CASW;
            S_CASW:  if (beat_q == CASW_LAST) state_d = S_CAPT;
            S_CAPT:  if (beat_q == BURST_LAST) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        bank_d = bank_q;
        if (state_q == S_IDLE && state_d == S_ACT) begin
            row_d  = irow;
            col_d  = icolumn;
            bank_d = ibank;
        end

        beat_d = beat_q + 4'd1;
        if (state_d != state_q && (state_d == S_CASW || state_d == S_CAPT)) begin
            beat_d = 4'd0;
        end
    end

    // Bus values come from next_state so they line up with the state they belong to.
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = 13'd0;
        ba_d   = 2'd0;
        dqm_d  = 2'b11;
        case (state_d)
            S_ACT: begin
                cmd_d  = CMD_BACT;
                addr_d = irow;
                ba_d   = ibank;
            end
            S_RD: begin
                cmd_d  = CMD_READ;
                addr_d = {3'b001, col_q};
                ba_d   = bank_q;
                dqm_d  = 2'b00;
            end
            S_CASW, S_CAPT: dqm_d = 2'b00;
            default: ;
        endcase

        ovalid_d = (state_d == S_CAPT);
        odata_d  = ovalid_d ? dq_sel : odata_q;
        ofin_d   = (state_d == S_FIN);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q  <= S_IDLE;
            row_q    <= 13'd0;
            col_q    <= 10'd0;
            bank_q   <= 2'd0;
            beat_q   <= 4'd0;
            cmd_q    <= CMD_NOP;
            addr_q   <= 13'd0;
            ba_q     <= 2'd0;
            dqm_q    <= 2'b11;
            ofin_q   <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            bank_q   <= bank_d;
            beat_q   <= beat_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            ba_q     <= ba_d;
            dqm_q    <= dqm_d;
            ofin_q   <= ofin_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
        end
    end

    assign ofin   = ofin_q;
    assign ovalid = ovalid_q;
    assign odata  = odata_q;

    assign DRAM_CLK   = ienb ? ~iclk    : 1'bz;
    assign DRAM_CKE   = ienb ? 1'b1     : 1'bz;
    assign DRAM_ADDR  = ienb ? addr_q   : 13'bz;
    assign DRAM_BA    = ienb ? ba_q     : 2'bz;
    assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
    assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
    assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
    assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
    assign DRAM_UDQM  = ienb ? dqm_q[1] : 1'bz;
    assign DRAM_LDQM  = ienb ? dqm_q[0] : 1'bz;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: two instances (CL=2/BL=1 and CL=3/BL=8) checked every cycle
// against a cycle-offset model of the transaction timeline.
module tb_sdram_read;

    logic iclk = 1'b0;
    always #5 iclk = ~iclk;

    logic        ireset, ireq, ienb;
    logic [12:0] irow;
    logic [9:0]  icolumn;
    logic [1:0]  ibank;
    logic [15:0] dq_a, dq_b;

    wire         ofin_a, ovalid_a, ofin_b, ovalid_b;
    wire  [15:0] odata_a, odata_b;
    wire         clk_a, cke_a, cs_a, ras_a, cas_a, we_a, udqm_a, ldqm_a;
    wire         clk_b, cke_b, cs_b, ras_b, cas_b, we_b, udqm_b, ldqm_b;
    wire  [12:0] addr_a, addr_b;
    wire  [1:0]  ba_a, ba_b;

    // Weak pulls reveal whether the pins are released when ienb=0.
    pulldown (cke_a);
    pullup   (cs_a);

    sdram_read #(.CAS_LATENCY(2), .BURST_LEN(1)) u_a (
        .iclk(iclk), .ireset(ireset), .ireq(ireq), .ienb(ienb), .ofin(ofin_a),
        .irow(irow), .icolumn(icolumn), .ibank(ibank), .odata(odata_a), .ovalid(ovalid_a),
        .DRAM_CLK(clk_a), .DRAM_CKE(cke_a), .DRAM_ADDR(addr_a), .DRAM_BA(ba_a),
        .DRAM_CS_N(cs_a), .DRAM_RAS_N(ras_a), .DRAM_CAS_N(cas_a), .DRAM_WE_N(we_a),
        .DRAM_UDQM(udqm_a), .DRAM_LDQM(ldqm_a), .DRAM_DQ(dq_a)
    );

    sdram_read #(.CAS_LATENCY(3), .BURST_LEN(8)) u_b (
        .iclk(iclk), .ireset(ireset), .ireq(ireq), .ienb(ienb), .ofin(ofin_b),
        .irow(irow), .icolumn(icolumn), .ibank(ibank), .odata(odata_b), .ovalid(ovalid_b),
        .DRAM_CLK(clk_b), .DRAM_CKE(cke_b), .DRAM_ADDR(addr_b), .DRAM_BA(ba_b),
        .DRAM_CS_N(cs_b), .DRAM_RAS_N(ras_b), .DRAM_CAS_N(cas_b), .DRAM_WE_N(we_b),
        .DRAM_UDQM(udqm_b), .DRAM_LDQM(ldqm_b), .DRAM_DQ(dq_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: each transaction is a timeline of offsets k from the accepting cycle.
    int          cl_p [2] = '{2, 3};
    int          bl_p [2] = '{1, 8};
    int          lat  [2];
    bit          busy [2];
    int          s    [2];
    logic [12:0] m_row  [2];
    logic [9:0]  m_col  [2];
    logic [1:0]  m_bank [2];
    logic [15:0] m_data [2][8];
    logic [15:0] last_od[2];
    logic [15:0] fdata  [2][8];
    bit          fdata_en = 1'b0;
    bit          model_ok = 1'b0;

    logic        nx_rst, nx_req, nx_enb;
    logic [12:0] nx_row;
    logic [9:0]  nx_col;
    logic [1:0]  nx_bank;

    task automatic run_cycle();
        logic [3:0]  o_cmd [2];
        logic [12:0] o_addr[2];
        logic [1:0]  o_ba  [2];
        logic [1:0]  o_dqm [2];
        logic        o_val [2];
        logic        o_fin [2];
        logic [15:0] o_od  [2];
        logic [15:0] dqv;
        logic [3:0]  e_cmd;
        logic [12:0] e_addr;
        logic [1:0]  e_ba, e_dqm;
        logic        e_val, e_fin;
        int          k, j;

        @(posedge iclk);
        #1;
        cyc++;
        ireset = nx_rst; ireq = nx_req; ienb = nx_enb;
        irow = nx_row; icolumn = nx_col; ibank = nx_bank;
        for (int i = 0; i < 2; i++) begin
            dqv = 16'($urandom);
            if (busy[i]) begin
                j = cyc - s[i] - 3 - cl_p[i];
                if (j >= 0 && j < bl_p[i]) dqv = m_data[i][j];
            end
            if (i == 0) dq_a = dqv; else dq_b = dqv;
        end

        @(negedge iclk);
        o_cmd[0] = {cs_a, ras_a, cas_a, we_a}; o_cmd[1] = {cs_b, ras_b, cas_b, we_b};
        o_addr[0] = addr_a; o_addr[1] = addr_b;
        o_ba[0] = ba_a; o_ba[1] = ba_b;
        o_dqm[0] = {udqm_a, ldqm_a}; o_dqm[1] = {udqm_b, ldqm_b};
        o_val[0] = ovalid_a; o_val[1] = ovalid_b;
        o_fin[0] = ofin_a; o_fin[1] = ofin_b;
        o_od[0] = odata_a; o_od[1] = odata_b;

        if (model_ok) begin
            if (ienb) begin
                check("cke_driven", 32'(cke_a), 32'd1);
                check("dram_clk", 32'(clk_a), 32'd1);
            end else begin
                check("cke_released", 32'(cke_a), 32'd0);
                check("cs_released", 32'(cs_a), 32'd1);
            end
            for (int i = 0; i < 2; i++) begin
                k = cyc - s[i];
                e_cmd = 4'b0111; e_addr = 13'd0; e_ba = 2'd0; e_dqm = 2'b11;
                e_val = 1'b0; e_fin = 1'b0;
                if (busy[i]) begin
                    if (k == 1) begin
                        e_cmd = 4'b0011; e_addr = m_row[i]; e_ba = m_bank[i];
                    end else if (k == 3) begin
                        e_cmd = 4'b0101; e_addr = {3'b001, m_col[i]}; e_ba = m_bank[i];
                    end
                    if (k >= 3 && k <= 3 + lat[i] + bl_p[i]) e_dqm = 2'b00;
                    if (k >= 4 + lat[i] && k <= 3 + lat[i] + bl_p[i]) begin
                        e_val = 1'b1;
                        last_od[i] = m_data[i][k - 4 - lat[i]];
                    end
                    e_fin = (k == 4 + lat[i] + bl_p[i]);
                end
                if (ienb) begin
                    check($sformatf("cmd%0d", i), 32'(o_cmd[i]), 32'(e_cmd));
                    check($sformatf("addr%0d", i), 32'(o_addr[i]), 32'(e_addr));
                    check($sformatf("ba%0d", i), 32'(o_ba[i]), 32'(e_ba));
                    check($sformatf("dqm%0d", i), 32'(o_dqm[i]), 32'(e_dqm));
                end
                check($sformatf("ovalid%0d", i), 32'(o_val[i]), 32'(e_val));
                check($sformatf("ofin%0d", i), 32'(o_fin[i]), 32'(e_fin));
                check($sformatf("odata%0d", i), 32'(o_od[i]), 32'(last_od[i]));
            end
        end

        for (int i = 0; i < 2; i++) begin
            k = cyc - s[i];
            if (ireset) begin
                busy[i] = 1'b0;
                last_od[i] = 16'h0000;
            end else if (busy[i] && k == 4 + lat[i] + bl_p[i]) begin
                busy[i] = 1'b0;
            end else if (!busy[i] && ireq && ienb) begin
                busy[i] = 1'b1;
                s[i] = cyc;
                m_row[i] = irow; m_col[i] = icolumn; m_bank[i] = ibank;
                for (int b = 0; b < 8; b++)
                    m_data[i][b] = fdata_en ? fdata[i][b] : 16'($urandom);
            end
        end
        if (ireset) model_ok = 1'b1;
    endtask

    task automatic rand_addr();
        nx_row  = 13'($urandom);
        nx_col  = 10'($urandom);
        nx_bank = 2'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
`ifdef SDRAM_READ_REGIN_EN
            lat[i] = cl_p[i] + 1;
`else
            lat[i] = cl_p[i];
`endif
            busy[i] = 1'b0; s[i] = 0; last_od[i] = 16'h0000;
        end
        ireset = 1'b1; ireq = 1'b0; ienb = 1'b1;
        irow = '0; icolumn = '0; ibank = '0; dq_a = '0; dq_b = '0;
        nx_rst = 1'b1; nx_req = 1'b0; nx_enb = 1'b1;
        nx_row = '0; nx_col = '0; nx_bank = '0;

        repeat (3) run_cycle();
        nx_rst = 1'b0;
        repeat (4) run_cycle();

        // Directed single read on both instances.
        nx_row = 13'h0123; nx_col = 10'h045; nx_bank = 2'd2;
        fdata[0][0] = 16'hBEEF;
        for (int b = 1; b < 8; b++) fdata[0][b] = 16'h0;
        for (int b = 0; b < 8; b++) fdata[1][b] = 16'(b);
        fdata_en = 1'b1;
        nx_req = 1'b1;
        run_cycle();
        nx_req = 1'b0;
        rand_addr();
        repeat (20) run_cycle();
        fdata_en = 1'b0;

        // Request held high while addresses keep changing.
        nx_req = 1'b1;
        repeat (45) begin
            rand_addr();
            run_cycle();
        end
        nx_req = 1'b0;
        repeat (20) run_cycle();

        // Reset landing in CASW on both instances, then a fresh read.
        nx_req = 1'b1; rand_addr();
        run_cycle();
        nx_req = 1'b0;
        repeat (4) run_cycle();
        nx_rst = 1'b1;
        run_cycle();
        nx_rst = 1'b0;
        repeat (3) run_cycle();
        nx_req = 1'b1; rand_addr();
        run_cycle();
        nx_req = 1'b0;
        repeat (20) run_cycle();

        // Bus not owned: request must be ignored and pins released.
        nx_enb = 1'b0; nx_req = 1'b1;
        repeat (6) run_cycle();
        nx_req = 1'b0; nx_enb = 1'b1;
        repeat (3) run_cycle();

        // Random traffic with occasional bus loss and resets.
        repeat (600) begin
            nx_req = ($urandom_range(0, 3) == 0);
            nx_enb = ($urandom_range(0, 9) != 0);
            nx_rst = ($urandom_range(0, 79) == 0);
            rand_addr();
            run_cycle();
        end
        nx_req = 1'b0; nx_rst = 1'b0; nx_enb = 1'b1;
        repeat (20) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
